// File: rtl/road_pkg.sv
// Shared road geometry constants and types for the rival-car logic.
package road_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_H = 480;

  typedef logic [1:0] lane_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_SPAWN,
    S_DONE
  } spawn_state_t;

endpackage

// File: rtl/rival_car_spawner_slot_find.sv
// Priority encoder: lowest-index free rival-car slot.
module slot_find #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     free_mask,
  output logic [IDX_W-1:0] free_idx,
  output logic             any_free
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    // Scan downwards so the lowest free index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rival_car_spawner.sv
// Per-frame rival-car update: move/retire each slot, then maybe spawn one car.
module rival_car_spawner #(
  parameter int NUM_CARS   = 3,
  parameter int MIN_GAP    = 30,
  parameter int ROAD_LEFT  = 256,
  parameter int LANE_PITCH = 40,
  parameter int SCREEN_H   = road_pkg::SCREEN_H
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   frame_tick,
  input  logic                                   pause,
  input  logic [7:0]                             random_in,
  input  logic [3:0]                             scroll_speed,
  output logic [NUM_CARS-1:0]                    car_valid,
  output logic [NUM_CARS*road_pkg::COORD_W-1:0]  car_x,
  output logic [NUM_CARS*road_pkg::COORD_W-1:0]  car_y,
  output logic [15:0]                            cars_passed,
  output logic                                   busy,
  output logic                                   frame_done
);

  import road_pkg::*;

  localparam int SLOT_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

  spawn_state_t        state, state_nxt;
  logic [SLOT_W-1:0]   slot;
  logic [3:0]          spd;
  logic [7:0]          gap_cnt;
  lane_t               last_lane;

  logic [SLOT_W-1:0]   free_idx;
  logic                any_free;
  logic                accept;
  logic                last_slot;
  logic [COORD_W:0]    y_new;
  lane_t               lane_raw;
  lane_t               lane_pick;
  logic [COORD_W-1:0]  spawn_x;

  slot_find #(
    .N     (NUM_CARS),
    .IDX_W (SLOT_W)
  ) u_slot_find (
    .free_mask (~car_valid),
    .free_idx  (free_idx),
    .any_free  (any_free)
  );

  assign accept    = frame_tick && !pause;
  assign last_slot = (slot == SLOT_W'(NUM_CARS - 1));
  assign y_new     = {1'b0, car_y[int'(slot)*COORD_W +: COORD_W]} + (COORD_W+1)'(spd);
  assign lane_raw  = random_in[1:0];
  // Never spawn twice in a row in the same lane.
  assign lane_pick = (lane_raw == last_lane) ? lane_t'(lane_raw + 2'd1) : lane_raw;
  assign spawn_x   = COORD_W'(ROAD_LEFT + int'(lane_pick) * LANE_PITCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_MOVE;
      S_MOVE:  if (last_slot) state_nxt = S_SPAWN;
      S_SPAWN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with <= so every branch sees the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_valid   <= '0;
      car_x       <= '0;
      car_y       <= '0;
      cars_passed <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      slot        <= '0;
      spd         <= '0;
      gap_cnt     <= 8'(MIN_GAP);
      last_lane   <= '0;
    end else begin
      // Outputs are registered from the next state so they line up with it.
      busy       <= (state_nxt != S_IDLE);
      frame_done <= (state_nxt == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            spd  <= scroll_speed;
            slot <= '0;
          end
        end
        S_MOVE: begin
          if (car_valid[slot]) begin
            if (y_new >= (COORD_W+1)'(SCREEN_H)) begin
              car_valid[slot] <= 1'b0;
              if (cars_passed != 16'hFFFF) cars_passed <= cars_passed + 16'd1;
            end else begin
              car_y[int'(slot)*COORD_W +: COORD_W] <= y_new[COORD_W-1:0];
            end
          end
          if (!last_slot) slot <= slot + SLOT_W'(1);
        end
        S_SPAWN: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (any_free) begin
            car_valid[free_idx]                      <= 1'b1;
            car_x[int'(free_idx)*COORD_W +: COORD_W] <= spawn_x;
            car_y[int'(free_idx)*COORD_W +: COORD_W] <= '0;
            last_lane                                <= lane_pick;
            gap_cnt <= 8'(MIN_GAP) + 8'(random_in[7:4]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rival_car_spawner.sv
// Scoreboard bench: a frame-level road model predicts each frame's result.
module tb_rival_car_spawner;

  localparam int N       = 3;
  localparam int MIN_GAP = 30;
  localparam int SCR_H   = 480;

  typedef struct {
    logic [N-1:0]    valid;
    logic [N*10-1:0] x;
    logic [N*10-1:0] y;
    logic [15:0]     passed;
    int              cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_tick = 1'b0;
  logic            pause = 1'b0;
  logic [7:0]      random_in = '0;
  logic [3:0]      scroll_speed = '0;
  logic [N-1:0]    car_valid;
  logic [N*10-1:0] car_x;
  logic [N*10-1:0] car_y;
  logic [15:0]     cars_passed;
  logic            busy;
  logic            frame_done;

  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  exp_t sb[$];

  // Reference road state
  bit m_valid[N];
  int m_x[N];
  int m_y[N];
  int m_passed;
  int m_gap;
  int m_last;

  rival_car_spawner #(
    .NUM_CARS (N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .pause        (pause),
    .random_in    (random_in),
    .scroll_speed (scroll_speed),
    .car_valid    (car_valid),
    .car_x        (car_x),
    .car_y        (car_y),
    .cars_passed  (cars_passed),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_x[i] = 0;
      m_y[i] = 0;
    end
    m_passed = 0;
    m_gap    = MIN_GAP;
    m_last   = 0;
  endtask

  // One whole frame: move everything, then try one spawn.
  task automatic model_frame(input int spd, input int r, output exp_t e);
    int lane;
    int slot;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i]) begin
        if (m_y[i] + spd >= SCR_H) begin
          m_valid[i] = 1'b0;
          if (m_passed < 65535) m_passed++;
        end else begin
          m_y[i] = m_y[i] + spd;
        end
      end
    end
    if (m_gap > 0) begin
      m_gap--;
    end else begin
      slot = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
      if (slot >= 0) begin
        lane = r % 4;
        if (lane == m_last) lane = (lane + 1) % 4;
        m_valid[slot] = 1'b1;
        m_x[slot] = 256 + lane * 40;
        m_y[slot] = 0;
        m_last = lane;
        m_gap = MIN_GAP + r / 16;
      end
    end
    for (int i = 0; i < N; i++) begin
      e.valid[i]        = m_valid[i];
      e.x[i*10 +: 10]   = 10'(m_x[i]);
      e.y[i*10 +: 10]   = 10'(m_y[i]);
    end
    e.passed = 16'(m_passed);
    e.cyc    = 0;
  endtask

  // Monitor: every frame_done pulse is matched against the oldest prediction.
  always @(negedge clk) begin
    if (frame_done) begin
      if (sb.size() == 0) begin
        check("unexpected_frame_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("frame_done_latency", 32'(cyc), 32'(e.cyc));
        check("car_valid", 32'(car_valid), 32'(e.valid));
        check("cars_passed", 32'(cars_passed), 32'(e.passed));
        for (int i = 0; i < N; i++) begin
          if (e.valid[i]) begin
            check($sformatf("car_x[%0d]", i), 32'(car_x[i*10 +: 10]), 32'(e.x[i*10 +: 10]));
            check($sformatf("car_y[%0d]", i), 32'(car_y[i*10 +: 10]), 32'(e.y[i*10 +: 10]));
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (k >= 30) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input int spd, input int r, input bit extra_tick);
    exp_t e;
    @(negedge clk);
    pause        = 1'b0;
    scroll_speed = 4'(spd);
    random_in    = 8'(r);
    frame_tick   = 1'b1;
    model_frame(spd, r, e);
    @(posedge clk);
    #1;
    e.cyc = cyc + N + 1;
    sb.push_back(e);
    @(negedge clk);
    frame_tick = 1'b0;
    check("busy_after_tick", 32'(busy), 32'd1);
    // Speed changes mid-frame must not affect the latched value.
    scroll_speed = 4'($urandom_range(0, 15));
    if (extra_tick) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
    wait_idle();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic paused_tick();
    @(negedge clk);
    pause      = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    pause      = 1'b0;
    check("busy_after_paused_tick", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_car_valid", 32'(car_valid), 32'd0);
    check("reset_car_x", 32'(car_x), 32'd0);
    check("reset_car_y", 32'(car_y), 32'd0);
    check("reset_cars_passed", 32'(cars_passed), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);

    // First spawn lands on the 31st accepted tick.
    for (int f = 1; f <= 31; f++) begin
      run_frame($urandom_range(0, 3), 8'h13, 1'b0);
      if (f == 30) check("no_car_before_tick31", 32'(car_valid), 32'd0);
    end
    check("first_spawn_valid", 32'(car_valid[0]), 32'd1);
    check("first_spawn_x", 32'(car_x[9:0]), 32'd376);
    check("first_spawn_y", 32'(car_y[9:0]), 32'd0);

    // Slow traffic fills every slot.
    for (int f = 0; f < 250; f++) begin
      run_frame($urandom_range(0, 2), $urandom_range(0, 255), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 15) == 0) paused_tick();
    end
    // Fast traffic retires cars and frees slots.
    for (int f = 0; f < 200; f++) begin
      run_frame($urandom_range(8, 15), $urandom_range(0, 255), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 15) == 0) paused_tick();
    end
    for (int f = 0; f < 20; f++) run_frame(0, $urandom_range(0, 255), 1'b0);

    // Reset in the middle of MOVE: everything clears, no frame_done follows.
    @(negedge clk);
    scroll_speed = 4'd7;
    frame_tick   = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_car_valid", 32'(car_valid), 32'd0);
    check("midreset_car_x", 32'(car_x), 32'd0);
    check("midreset_car_y", 32'(car_y), 32'd0);
    check("midreset_cars_passed", 32'(cars_passed), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_frame_done", 32'(frame_done), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    for (int f = 0; f < 35; f++) run_frame($urandom_range(0, 15), $urandom_range(0, 255), 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rival_car_spawner.md
# rival_car_spawner

Manages the rival cars on the road: once per video frame it advances every active car down the screen by the current scroll speed and retires cars that leave the bottom edge. It then spawns a new car at the top of a randomly chosen lane after a random frame gap. It consumes the 8-bit pseudo-random byte from the game's LFSR and feeds car positions to the renderer and collision logic.

## Interface
- `NUM_CARS`, 3: number of rival-car slots (1–8).
- `MIN_GAP`, 30: minimum frames between spawns.
- `ROAD_LEFT`, 256: x coordinate of lane 0.
- `LANE_PITCH`, 40: x spacing between the four lanes.
- `SCREEN_H`, 480: y coordinate at which a car is retired.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per frame (vsync).
- `pause` in 1: when high, `frame_tick` is ignored.
- `random_in` in 8: LFSR byte; sampled only in SPAWN.
- `scroll_speed` in 4: pixels per frame; latched on an accepted tick.
- `car_valid` out NUM_CARS: slot occupied.
- `car_x` out NUM_CARS*10: packed x, slot i at [10i+9:10i].
- `car_y` out NUM_CARS*10: packed y, same packing.
- `cars_passed` out 16: count of cars retired off the bottom, saturating.
- `busy` out 1: high while not in IDLE.
- `frame_done` out 1: one-cycle pulse when a frame's update completes.

## Operation
**Reset values**
- All outputs are 0.
- Internal `gap_cnt` = MIN_GAP, `last_lane` = 0, FSM state = IDLE.

**FSM states**
- IDLE
  - On `frame_tick && !pause`: latch `scroll_speed` into `spd`, set slot index 0, go to MOVE.
  - Otherwise stay in IDLE.
- MOVE: processes one slot per cycle.
  - Valid slot: compute `y_new = car_y + spd` at 11-bit width.
  - If `y_new >= SCREEN_H`: clear `car_valid`, increment `cars_passed` (holds at 0xFFFF).
  - Else: `car_y = y_new[9:0]`.
  - Invalid slots are untouched.
  - After slot NUM_CARS-1, go to SPAWN.
- SPAWN: lasts exactly one cycle, then go to DONE.
  - If `gap_cnt != 0`: decrement `gap_cnt`.
  - Else if any slot is free:
    - Pick the lowest-index free slot.
    - Compute `lane = random_in[1:0]`; if `lane == last_lane`, use `lane + 1` mod 4.
    - Set `car_x = ROAD_LEFT + lane*LANE_PITCH` and `car_y = 0`, then set valid.
    - Set `last_lane = lane` and `gap_cnt = MIN_GAP + random_in[7:4]`.
  - Else (no free slot): `gap_cnt` stays 0 and the spawn is retried next frame.
- DONE: pulse `frame_done`, return to IDLE.

**Boundary rules**
- A car spawned this frame is not moved until the next frame.
- A car retired in MOVE frees its slot for the SPAWN of the same frame.
- `frame_tick` while `busy` is ignored; it is neither queued nor counted.
- `scroll_speed` = 0: cars stay in place, and spawning still proceeds.
- `rst` asserted mid-frame: all slots are cleared immediately; no `frame_done` pulse is issued.

## Timing
- Frame latency: an accepted tick in cycle T gives `busy` high T+1..T+NUM_CARS+2 and `frame_done` high at T+NUM_CARS+2. That is NUM_CARS+2 cycles (5 for the default).
- All outputs are registered. Position outputs are stable while `busy` is low; the renderer samples them then.
- First spawn after reset happens on the (MIN_GAP+1)-th accepted tick.

## Structure
- Shared package `road_pkg`:
  - `COORD_W` = 10 and `SCREEN_H`.
  - `lane_t` (2-bit) and the FSM state enum `spawn_state_t`.
- Sub-module `slot_find`: combinational priority encoder over `~car_valid`, outputting `free_idx` and `any_free`.
- Everything else lives in `rival_car_spawner`.

## Test plan
- **Reset, then first spawn.** Hold `random_in` = 0x13 and apply 31 ticks. Expect no car through tick 30; on tick 31, slot 0 becomes valid with x = 376, y = 0 and `gap_cnt` = 31.
- **Movement.** With one car at y = 0 and `scroll_speed` = 5, apply 3 ticks. Expect y = 15, and `frame_done` 5 cycles after each tick.
- **Retirement.** Car at y = 478 with speed 2: after the tick, `car_valid[0]` = 0 and `cars_passed` = 1. With the gap expired, the same frame respawns into slot 0.
- **Lane de-duplication.** Make `last_lane` = 2, then spawn with `random_in` = 0x02. Expect lane 3 (x = 376). With `last_lane` = 3 and `random_in` = 0x03, expect lane 0 (x = 256).
- **Slots full.** Fill 3 slots, then expire the gap. Expect no spawn, `gap_cnt` held at 0, and a spawn on the first frame after a slot frees.
- **Ignored ticks and reset.** Send a `frame_tick` while `busy` and another with `pause` = 1; expect no state change from either. Assert `rst` during MOVE; expect all outputs 0 and no `frame_done` pulse.
